// File: rtl/ext_dtcm_bridge.sv
// ext_dtcm_bridge: request FIFO -> DTCM arbiter ext channel -> ordered response FIFO.
// Optional misaligned-address rejection when EXT_DTCM_ALIGN_CHK_EN is defined.
package ext_dtcm_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  strb;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;
endpackage

module ext_dtcm_bridge
  import ext_dtcm_pkg::*;
#(
  parameter int unsigned REQ_DEPTH = 2,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_req_valid_i,
  output logic        s_req_ready_o,
  input  logic [31:0] s_req_addr_i,
  input  logic        s_req_we_i,
  input  logic [31:0] s_req_wdata_i,
  input  logic [3:0]  s_req_strb_i,
  output logic        s_rsp_valid_o,
  input  logic        s_rsp_ready_i,
  output logic [31:0] s_rsp_rdata_o,
  output logic        s_rsp_error_o,
  output lsu_req_t    ext_dtcm_req_o,
  input  lsu_ack_t    ext_dtcm_ack_i,
  output logic        busy_o
);
  localparam int unsigned RAW = $clog2(REQ_DEPTH);
  localparam int unsigned SAW = $clog2(RSP_DEPTH);
  localparam logic [SAW+1:0] RSP_LIM = (SAW+2)'(RSP_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  strb;
  } req_ent_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_ent_t;

  req_ent_t       req_mem_q [REQ_DEPTH];
  rsp_ent_t       rsp_mem_q [RSP_DEPTH];
  logic [RAW:0]   req_wp_q, req_wp_d, req_rp_q, req_rp_d;
  logic [SAW:0]   rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  logic           pend_v_q, pend_v_d;
  logic           pend_we_q, pend_we_d;
  logic           pend_err_q, pend_err_d;

  logic           req_empty, req_full, rsp_empty;
  logic           req_push, req_pop, rsp_push, rsp_pop;
  logic           issue, head_mis;
  logic [SAW+1:0] rsp_used;
  req_ent_t       head, req_in;
  rsp_ent_t       rsp_in, rsp_head;

  assign req_empty = (req_wp_q == req_rp_q);
  assign req_full  = (req_wp_q[RAW] != req_rp_q[RAW]) &&
                     (req_wp_q[RAW-1:0] == req_rp_q[RAW-1:0]);
  assign rsp_empty = (rsp_wp_q == rsp_rp_q);

  assign head     = req_mem_q[req_rp_q[RAW-1:0]];
  assign rsp_head = rsp_mem_q[rsp_rp_q[SAW-1:0]];

  assign req_in.addr  = s_req_addr_i;
  assign req_in.wdata = s_req_wdata_i;
  assign req_in.we    = s_req_we_i;
  assign req_in.strb  = s_req_strb_i;

  assign s_req_ready_o = ~req_full;
  assign req_push      = s_req_valid_i & ~req_full;

`ifdef EXT_DTCM_ALIGN_CHK_EN
  assign head_mis = |head.addr[1:0];
`else
  assign head_mis = 1'b0;
`endif

  // An acked request keeps its credit in stage 1 until it lands in the response FIFO,
  // so the response FIFO can never be overrun.
  assign rsp_used = {1'b0, rsp_wp_q - rsp_rp_q} + {{(SAW+1){1'b0}}, pend_v_q};
  assign issue    = ~req_empty & (rsp_used < RSP_LIM);
  assign req_pop  = issue & (head_mis | ext_dtcm_ack_i.ack);

  always_comb begin
    ext_dtcm_req_o = '0;
    if (issue && !head_mis) begin
      ext_dtcm_req_o.req   = 1'b1;
      ext_dtcm_req_o.addr  = head.addr;
      ext_dtcm_req_o.wdata = head.wdata;
      ext_dtcm_req_o.we    = head.we;
      ext_dtcm_req_o.strb  = head.strb;
    end
  end

  // SRAM read data arrives the cycle after the ack, alongside the stage-1 entry.
  assign rsp_push     = pend_v_q;
  assign rsp_in.rdata = (pend_we_q | pend_err_q) ? 32'h0 : ext_dtcm_ack_i.rdata;
  assign rsp_in.error = pend_err_q;
  assign rsp_pop      = ~rsp_empty & s_rsp_ready_i;

  assign s_rsp_valid_o = ~rsp_empty;
  assign s_rsp_rdata_o = rsp_empty ? 32'h0 : rsp_head.rdata;
  assign s_rsp_error_o = ~rsp_empty & rsp_head.error;
  assign busy_o        = ~req_empty | pend_v_q | ~rsp_empty;

  always_comb begin
    req_wp_d   = req_wp_q;
    req_rp_d   = req_rp_q;
    rsp_wp_d   = rsp_wp_q;
    rsp_rp_d   = rsp_rp_q;
    if (req_push) req_wp_d = req_wp_q + {{RAW{1'b0}}, 1'b1};
    if (req_pop)  req_rp_d = req_rp_q + {{RAW{1'b0}}, 1'b1};
    if (rsp_push) rsp_wp_d = rsp_wp_q + {{SAW{1'b0}}, 1'b1};
    if (rsp_pop)  rsp_rp_d = rsp_rp_q + {{SAW{1'b0}}, 1'b1};
    pend_v_d   = req_pop;
    pend_we_d  = head.we;
    pend_err_d = head_mis | ext_dtcm_ack_i.error;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_wp_q   <= '0;
      req_rp_q   <= '0;
      rsp_wp_q   <= '0;
      rsp_rp_q   <= '0;
      pend_v_q   <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      req_wp_q   <= req_wp_d;
      req_rp_q   <= req_rp_d;
      rsp_wp_q   <= rsp_wp_d;
      rsp_rp_q   <= rsp_rp_d;
      pend_v_q   <= pend_v_d;
      pend_we_q  <= pend_we_d;
      pend_err_q <= pend_err_d;
    end
  end

  // Storage needs no reset: pointers alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (req_push) req_mem_q[req_wp_q[RAW-1:0]] <= req_in;
    if (rsp_push) rsp_mem_q[rsp_wp_q[SAW-1:0]] <= rsp_in;
  end
endmodule

// File: tb/tb_ext_dtcm_bridge.sv
// Bench for ext_dtcm_bridge: vector table, directed stall/back-pressure/stream/reset cases,
// and a randomized run scored against a queue model. Also builds with EXT_DTCM_ALIGN_CHK_EN.
`timescale 1ns/1ps
module tb_ext_dtcm_bridge;
  import ext_dtcm_pkg::*;

  localparam int REQ_DEPTH = 2;
  localparam int RSP_DEPTH = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        s_req_valid = 1'b0, s_req_ready, s_req_we = 1'b0;
  logic [31:0] s_req_addr = '0, s_req_wdata = '0;
  logic [3:0]  s_req_strb = '0;
  logic        s_rsp_valid, s_rsp_ready = 1'b0, s_rsp_error;
  logic [31:0] s_rsp_rdata;
  lsu_req_t    dreq;
  lsu_ack_t    dack = '0;
  logic        busy;

  ext_dtcm_bridge #(.REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_req_valid_i(s_req_valid), .s_req_ready_o(s_req_ready),
    .s_req_addr_i(s_req_addr), .s_req_we_i(s_req_we),
    .s_req_wdata_i(s_req_wdata), .s_req_strb_i(s_req_strb),
    .s_rsp_valid_o(s_rsp_valid), .s_rsp_ready_i(s_rsp_ready),
    .s_rsp_rdata_o(s_rsp_rdata), .s_rsp_error_o(s_rsp_error),
    .ext_dtcm_req_o(dreq), .ext_dtcm_ack_i(dack), .busy_o(busy)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb; } treq_t;
  typedef struct { logic [31:0] rdata; logic err; logic hs; } trsp_t;
  typedef struct {
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb; logic aerr;
    logic [31:0] exp_rdata; logic exp_err; int exp_hs;
  } vec_t;

  treq_t send_q[$], iq[$];
  trsp_t rq[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, outst = 0, n_hs = 0, n_rsp = 0, n_stall = 0;
  int push_cyc = 0, pop_cyc = 0, gap_ref = -1, max_gap = 0;
  int p_valid = 0, p_ack = 100, p_rrdy = 100, p_err = 0;
  logic rst_drv = 1'b0, occ_chk = 1'b1;
  logic rd_pend = 1'b0, prev_stall = 1'b0;
  logic [31:0] rd_addr = '0;
  lsu_req_t prev_req = '0;

  // SRAM content model
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic q_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    treq_t t;
    t.addr = a; t.we = w; t.wdata = d; t.strb = s;
    send_q.push_back(t);
  endtask

`ifdef EXT_DTCM_ALIGN_CHK_EN
  // Misaligned heads leave without a DTCM handshake and answer with an error.
  task automatic drain_mis();
    trsp_t r;
    while (iq.size() > 0 && iq[0].addr[1:0] != 2'b00) begin
      void'(iq.pop_front());
      r.rdata = '0; r.err = 1'b1; r.hs = 1'b0;
      rq.push_back(r);
    end
  endtask
`endif

  // Values seen here are the ones the DUT samples at the coming posedge.
  task automatic observe();
    treq_t e;
    trsp_t r;
    if (!rst_n) begin
      iq.delete(); rq.delete();
      outst = 0; rd_pend = 1'b0; prev_stall = 1'b0;
      return;
    end
    if (occ_chk) begin
      chk("req_ready", {31'h0, s_req_ready}, {31'h0, iq.size() < REQ_DEPTH});
      chk("busy", {31'h0, busy}, {31'h0, (iq.size() > 0) || (outst > 0)});
    end
    if (!dreq.req) chk("req_idle_zero", {31'h0, dreq == '0}, 32'h1);
    if (prev_stall) begin
      chk("stall_hold_req", {31'h0, dreq.req}, 32'h1);
      chk("stall_hold_fields", {31'h0, dreq == prev_req}, 32'h1);
    end
`ifdef EXT_DTCM_ALIGN_CHK_EN
    if (dreq.req) chk("no_misaligned_req", {30'h0, dreq.addr[1:0]}, 32'h0);
`endif
    prev_stall = dreq.req && !dack.ack;
    prev_req   = dreq;
    if (prev_stall) n_stall++;

    if (s_rsp_valid && s_rsp_ready) begin
`ifdef EXT_DTCM_ALIGN_CHK_EN
      if (rq.size() == 0) drain_mis();
`endif
      if (rq.size() == 0) bad("unexpected_rsp");
      else begin
        r = rq.pop_front();
        chk("rsp_rdata", s_rsp_rdata, r.rdata);
        chk("rsp_error", {31'h0, s_rsp_error}, {31'h0, r.err});
        if (r.hs) outst--;
      end
      n_rsp++;
      if (gap_ref >= 0 && cyc - gap_ref > max_gap) max_gap = cyc - gap_ref;
      gap_ref = cyc;
      pop_cyc = cyc;
    end

    if (dreq.req && dack.ack) begin
`ifdef EXT_DTCM_ALIGN_CHK_EN
      drain_mis();
`endif
      n_hs++;
      if (iq.size() == 0) bad("unexpected_dtcm_req");
      else begin
        e = iq.pop_front();
        chk("hs_addr", dreq.addr, e.addr);
        chk("hs_we", {31'h0, dreq.we}, {31'h0, e.we});
        chk("hs_wdata", dreq.wdata, e.wdata);
        chk("hs_strb", {28'h0, dreq.strb}, {28'h0, e.strb});
        r.rdata = (e.we || dack.error) ? 32'h0 : mem_rd(e.addr);
        r.err = dack.error; r.hs = 1'b1;
        rq.push_back(r);
        outst++;
        chk("credit_limit", {31'h0, outst <= RSP_DEPTH}, 32'h1);
      end
      rd_pend = 1'b1; rd_addr = dreq.addr;
    end else rd_pend = 1'b0;

    if (s_req_valid && s_req_ready) begin
      iq.push_back(send_q.pop_front());
      push_cyc = cyc;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    rst_n = rst_drv;
    s_req_valid = (send_q.size() > 0) && roll(p_valid);
    if (send_q.size() > 0) begin
      s_req_addr = send_q[0].addr; s_req_we = send_q[0].we;
      s_req_wdata = send_q[0].wdata; s_req_strb = send_q[0].strb;
    end else begin
      s_req_addr = $urandom(); s_req_we = 1'($urandom()); s_req_wdata = $urandom(); s_req_strb = 4'($urandom());
    end
    s_rsp_ready = roll(p_rrdy);
    dack.ack    = roll(p_ack);
    dack.error  = roll(p_err);
    // Junk when no read is due, so a wrongly timed sample shows up.
    dack.rdata  = rd_pend ? mem_rd(rd_addr) : $urandom();
    #1;
    observe();
  endtask

  task automatic run_until_idle(input string name, input int max_cyc);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!(send_q.size() == 0 && iq.size() == 0 && rq.size() == 0 && !busy) && k < max_cyc);
    if (k >= max_cyc) bad({name, "_drain_timeout"});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, {31'h0, s_req_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'h0, s_rsp_valid}, 32'h0);
    chk({tag, "_rsp_rdata"}, s_rsp_rdata, 32'h0);
    chk({tag, "_rsp_error"}, {31'h0, s_rsp_error}, 32'h0);
    chk({tag, "_dtcm_req_zero"}, {31'h0, dreq == '0}, 32'h1);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int r0, h0, s0;
    logic got;

    vt[0] = '{32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 1};
    vt[1] = '{32'h20, 1'b1, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 1};
    vt[2] = '{32'h44, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1};
    vt[3] = '{32'h48, 1'b1, 32'hCAFEF00D, 4'h3, 1'b1, 32'h0, 1'b1, 1};
`ifdef EXT_DTCM_ALIGN_CHK_EN
    vt[4] = '{32'h102, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 0};
`else
    vt[4] = '{32'h102, 1'b0, 32'h0, 4'hF, 1'b0, mem_rd(32'h102), 1'b0, 1};
`endif

    rst_drv = 1'b0;
    cycle(); cycle();
    @(posedge clk); #1;
    chk_reset("reset");
    rst_drv = 1'b1;
    cycle();

    // Single transactions, ack=1, rsp_ready=1: response 3 cycles after push.
    for (int i = 0; i < 5; i++) begin
      p_valid = 100; p_ack = 100; p_rrdy = 100; p_err = vt[i].aerr ? 100 : 0;
`ifdef EXT_DTCM_ALIGN_CHK_EN
      occ_chk = (vt[i].addr[1:0] == 2'b00);
`endif
      q_req(vt[i].addr, vt[i].we, vt[i].wdata, vt[i].strb);
      h0 = n_hs; got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        cycle();
        if (s_rsp_valid && s_rsp_ready) begin
          got = 1'b1;
          chk($sformatf("vec%0d_rdata", i), s_rsp_rdata, vt[i].exp_rdata);
          chk($sformatf("vec%0d_error", i), {31'h0, s_rsp_error}, {31'h0, vt[i].exp_err});
        end
      end
      if (!got) bad($sformatf("vec%0d_no_rsp", i));
      else chk($sformatf("vec%0d_latency", i), pop_cyc - push_cyc, 3);
      chk($sformatf("vec%0d_dtcm_hs", i), n_hs - h0, vt[i].exp_hs);
      p_err = 0;
      run_until_idle("vec", 20);
      occ_chk = 1'b1;
    end

    // Arbiter stall on a write: request held 5 cycles, then exactly one response.
    p_valid = 100; p_ack = 0; p_rrdy = 100; p_err = 0;
    q_req(32'h20, 1'b1, 32'h12345678, 4'hF);
    s0 = n_stall; r0 = n_rsp;
    repeat (6) cycle();
    chk("stall_cycles", n_stall - s0, 5);
    chk("stall_addr", dreq.addr, 32'h20);
    chk("stall_wdata", dreq.wdata, 32'h12345678);
    chk("stall_strb", {28'h0, dreq.strb}, 32'hF);
    p_ack = 100;
    run_until_idle("stall", 20);
    chk("stall_rsp_count", n_rsp - r0, 1);

    // Response back-pressure: two credits, then the request FIFO fills.
    p_valid = 100; p_ack = 100; p_rrdy = 0;
    for (int i = 0; i < 6; i++) q_req(32'h200 + 32'(4 * i), 1'b0, 32'h0, 4'hF);
    h0 = n_hs; r0 = n_rsp;
    repeat (12) cycle();
    chk("bp_issued", n_hs - h0, RSP_DEPTH);
    chk("bp_req_ready", {31'h0, s_req_ready}, 32'h0);
    chk("bp_no_rsp", n_rsp - r0, 0);
    p_rrdy = 100;
    run_until_idle("bp", 60);
    chk("bp_rsp_count", n_rsp - r0, 6);

    // Streaming: occupancy-based credit with two response slots sustains
    // two responses every three cycles, so no gap may exceed two cycles.
    p_valid = 100; p_ack = 100; p_rrdy = 100;
    for (int i = 0; i < 16; i++) q_req(32'h400 + 32'(4 * i), 1'b0, 32'h0, 4'hF);
    r0 = n_rsp; gap_ref = -1; max_gap = 0;
    run_until_idle("stream", 100);
    chk("stream_rsp_count", n_rsp - r0, 16);
    chk("stream_max_gap", {31'h0, max_gap <= 2 && max_gap >= 1}, 32'h1);

    // Reset with one response buffered, one in stage 1 and one queued.
    p_valid = 100; p_ack = 100; p_rrdy = 0;
    for (int i = 0; i < 4; i++) q_req(32'h600 + 32'(4 * i), 1'b0, 32'h0, 4'hF);
    repeat (3) cycle();
    send_q.delete();
    rst_drv = 1'b0;
    cycle();
    @(posedge clk); #1;
    chk_reset("midrst");
    rst_drv = 1'b1; p_rrdy = 100;
    r0 = n_rsp;
    repeat (10) cycle();
    chk("midrst_no_stale_rsp", n_rsp - r0, 0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 150; i++) begin
`ifdef EXT_DTCM_ALIGN_CHK_EN
      q_req($urandom() & 32'hFFFF_FFFC, 1'($urandom()), $urandom(), 4'($urandom()));
`else
      q_req($urandom(), 1'($urandom()), $urandom(), 4'($urandom()));
`endif
    end
    r0 = n_rsp;
    p_valid = 60; p_ack = 70; p_rrdy = 60; p_err = 15;
    repeat (400) cycle();
    p_valid = 100; p_ack = 100; p_rrdy = 100; p_err = 0;
    run_until_idle("rand", 400);
    chk("rand_rsp_count", n_rsp - r0, 150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
